mux_sweep_controller: RTL and testbench

MUX_SWEEP_CONTROLLER -- requirements
Module: mux_sweep_controller

---
 rtl/mux_sweep_controller.sv | 126 ++++++++++++
 tb/tb_mux_sweep_controller.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_sweep_controller.sv
// Exhaustive sweep of all 256 {sel,data} vectors into two mux implementations,
// counting output mismatches and capturing the first failing vector.
module mux_sweep_controller #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       hold,
    input  logic       f1,
    input  logic       f2,
    output logic [2:0] sel,
    output logic [4:0] data,
    output logic       busy,
    output logic       done,
    output logic [8:0] err_count,
    output logic       err_valid,
    output logic [7:0] first_err_vec,
    output logic       pass
);

    localparam int unsigned VecW = 8;
    localparam int unsigned CntW = 4;
    localparam int unsigned ErrW = 9;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t            state, stateNext;
    logic [VecW-1:0]   vec, vecNext;
    logic [CntW-1:0]   cnt, cntNext;
    logic [ErrW-1:0]   errCount, errCountNext;
    logic              errValid, errValidNext;
    logic [VecW-1:0]   firstErr, firstErrNext;
    logic              busyQ, doneQ, passQ;

    // Next-state and datapath updates; hold freezes everything while sweeping
    always_comb begin
        stateNext    = state;
        vecNext      = vec;
        cntNext      = cnt;
        errCountNext = errCount;
        errValidNext = errValid;
        firstErrNext = firstErr;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    stateNext    = SETTLE;
                    vecNext      = '0;
                    cntNext      = '0;
                    errCountNext = '0;
                    errValidNext = 1'b0;
                    firstErrNext = '0;
                end
            end
            SETTLE: begin
                if (!hold) begin
                    cntNext = cnt + 1'b1;
                    if (cnt == CntW'(SETTLE_CYCLES - 1)) begin
                        stateNext = CHECK;
                    end
                end
            end
            CHECK: begin
                if (!hold) begin
                    if (f1 != f2) begin
                        if (errCount != '1) begin
                            errCountNext = errCount + 1'b1;
                        end
                        if (!errValid) begin
                            errValidNext = 1'b1;
                            firstErrNext = vec;
                        end
                    end
                    cntNext = '0;
                    if (vec == '1) begin
                        stateNext = DONE;
                    end else begin
                        vecNext   = vec + 1'b1;
                        stateNext = SETTLE;
                    end
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // Status flags are registered from the next-state view so they align with state
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            vec      <= '0;
            cnt      <= '0;
            errCount <= '0;
            errValid <= 1'b0;
            firstErr <= '0;
            busyQ    <= 1'b0;
            doneQ    <= 1'b0;
            passQ    <= 1'b0;
        end else begin
            state    <= stateNext;
            vec      <= vecNext;
            cnt      <= cntNext;
            errCount <= errCountNext;
            errValid <= errValidNext;
            firstErr <= firstErrNext;
            busyQ    <= (stateNext == SETTLE) || (stateNext == CHECK);
            doneQ    <= (stateNext == DONE);
            passQ    <= (stateNext == DONE) && (errCountNext == '0);
        end
    end

    assign sel           = vec[7:5];
    assign data          = vec[4:0];
    assign busy          = busyQ;
    assign done          = doneQ;
    assign err_count     = errCount;
    assign err_valid     = errValid;
    assign first_err_vec = firstErr;
    assign pass          = passQ;

endmodule

// File: tb/tb_mux_sweep_controller.sv
// Scoreboard bench: two controllers (settle 1 and 3) against modelled mux pairs.
module tb_mux_sweep_controller;

    typedef struct {
        int unsigned doneCycle;
        logic [8:0]  errCount;
        logic        errValid;
        logic [7:0]  firstErr;
        logic        pass;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset[2];
    logic         start[2];
    logic         hold[2];
    logic         f1[2];
    logic         f2[2];
    logic [2:0]   sel[2];
    logic [4:0]   data[2];
    logic         busy[2];
    logic         done[2];
    logic [8:0]   errCount[2];
    logic         errValid[2];
    logic [7:0]   firstErr[2];
    logic         pass[2];
    logic         stuck[2];
    logic [255:0] fmap[2];
    logic         prevDone[2];

    int unsigned cyc = 0;
    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    exp_t expQ0[$];
    exp_t expQ1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference 5:1 mux: data bit selected by sel, zero for sel 5..7
    function automatic logic muxRef(logic [7:0] v);
        logic [2:0] s;
        s = v[7:5];
        if (s < 3'd5) return v[s];
        return 1'b0;
    endfunction

    function automatic logic f2Model(logic stuck0, logic [255:0] map, logic [7:0] v);
        if (stuck0) return 1'b0;
        return muxRef(v) ^ map[v];
    endfunction

    function automatic int unsigned settleOf(int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic exp_t model(logic stuck0, logic [255:0] map, int unsigned se,
                                   int unsigned sc, int unsigned holdLen);
        exp_t e;
        e.errCount = '0;
        e.errValid = 1'b0;
        e.firstErr = '0;
        for (int v = 0; v < 256; v++) begin
            if (muxRef(8'(v)) != f2Model(stuck0, map, 8'(v))) begin
                if (!e.errValid) e.firstErr = 8'(v);
                e.errValid = 1'b1;
                e.errCount = e.errCount + 9'd1;
            end
        end
        e.pass      = (e.errCount == 9'd0);
        e.doneCycle = se + 256 * (sc + 1) + holdLen;
        return e;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : gDut
        mux_sweep_controller #(.SETTLE_CYCLES((g == 0) ? 1 : 3)) u (
            .clk           (clk),
            .reset         (reset[g]),
            .start         (start[g]),
            .hold          (hold[g]),
            .f1            (f1[g]),
            .f2            (f2[g]),
            .sel           (sel[g]),
            .data          (data[g]),
            .busy          (busy[g]),
            .done          (done[g]),
            .err_count     (errCount[g]),
            .err_valid     (errValid[g]),
            .first_err_vec (firstErr[g]),
            .pass          (pass[g])
        );
        assign f1[g] = muxRef({sel[g], data[g]});
        assign f2[g] = f2Model(stuck[g], fmap[g], {sel[g], data[g]});
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, want, cyc);
        end
    endtask

    task automatic checkZero(int i, string tag);
        chk({tag, ".sel"}, 32'(sel[i]), 0);
        chk({tag, ".data"}, 32'(data[i]), 0);
        chk({tag, ".busy"}, 32'(busy[i]), 0);
        chk({tag, ".done"}, 32'(done[i]), 0);
        chk({tag, ".errCount"}, 32'(errCount[i]), 0);
        chk({tag, ".errValid"}, 32'(errValid[i]), 0);
        chk({tag, ".firstErr"}, 32'(firstErr[i]), 0);
        chk({tag, ".pass"}, 32'(pass[i]), 0);
    endtask

    // Monitor: on each rising done, pop the expected result and compare
    always @(negedge clk) begin
        exp_t e;
        bit   have;
        for (int i = 0; i < 2; i++) begin
            if (done[i] === 1'b1 && prevDone[i] !== 1'b1) begin
                have = (i == 0) ? (expQ0.size() != 0) : (expQ1.size() != 0);
                if (!have) begin
                    chk("unexpectedDone", 1, 0);
                end else begin
                    e = (i == 0) ? expQ0.pop_front() : expQ1.pop_front();
                    chk("doneCycle", cyc, e.doneCycle);
                    chk("errCount", 32'(errCount[i]), 32'(e.errCount));
                    chk("errValid", 32'(errValid[i]), 32'(e.errValid));
                    chk("firstErrVec", 32'(firstErr[i]), 32'(e.firstErr));
                    chk("pass", 32'(pass[i]), 32'(e.pass));
                end
            end
            prevDone[i] = done[i];
        end
    end

    task automatic runSweep(int i, logic stuck0, logic [255:0] map, int holdAt, int holdLen,
                            bit extraStart, bit doReset);
        exp_t        e;
        int unsigned se;
        int          n;
        stuck[i] = stuck0;
        fmap[i]  = map;
        @(negedge clk);
        start[i] = 1'b1;
        se = cyc + 1;
        e = model(stuck0, map, se, settleOf(i), int'(holdLen));
        if (!doReset) begin
            if (i == 0) expQ0.push_back(e);
            else        expQ1.push_back(e);
        end
        @(negedge clk);
        start[i] = 1'b0;
        chk("busyAfterStart", 32'(busy[i]), 1);
        chk("doneAfterStart", 32'(done[i]), 0);
        chk("errCountCleared", 32'(errCount[i]), 0);
        chk("errValidCleared", 32'(errValid[i]), 0);
        if (doReset) begin
            repeat (98) @(negedge clk);
            reset[i] = 1'b1;
            @(negedge clk);
            reset[i] = 1'b0;
            checkZero(i, "midReset");
            return;
        end
        if (holdLen > 0) begin
            repeat (holdAt) @(negedge clk);
            hold[i] = 1'b1;
            repeat (holdLen) @(negedge clk);
            chk("busyInHold", 32'(busy[i]), 1);
            hold[i] = 1'b0;
        end
        if (extraStart) begin
            repeat (7) @(negedge clk);
            start[i] = 1'b1;
            @(negedge clk);
            start[i] = 1'b0;
        end
        n = 0;
        while (done[i] !== 1'b1 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        if (done[i] !== 1'b1) chk("doneTimeout", 0, 1);
        hold[i] = 1'b1;
        repeat (6) @(negedge clk);
        hold[i] = 1'b0;
        chk("doneHeld", 32'(done[i]), 1);
        chk("resultStable", 32'(errCount[i]), 32'(e.errCount));
        chk("firstErrStable", 32'(firstErr[i]), 32'(e.firstErr));
        chk("passStable", 32'(pass[i]), 32'(e.pass));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [255:0] m44;
        logic [255:0] rmap;
        for (int i = 0; i < 2; i++) begin
            reset[i] = 1'b1;
            start[i] = 1'b1;
            hold[i]  = 1'b1;
            stuck[i] = 1'b0;
            fmap[i]  = '0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            checkZero(i, "reset");
            reset[i] = 1'b0;
            start[i] = 1'b0;
            hold[i]  = 1'b0;
        end
        @(negedge clk);
        checkZero(0, "idle");

        m44 = '0;
        m44[8'h44] = 1'b1;
        runSweep(0, 1'b0, '0, 0, 0, 1'b0, 1'b0);
        runSweep(0, 1'b0, m44, 0, 0, 1'b0, 1'b0);
        runSweep(0, 1'b1, '0, 0, 0, 1'b0, 1'b0);
        runSweep(0, 1'b0, m44, 0, 0, 1'b0, 1'b1);
        runSweep(0, 1'b0, '0, 0, 0, 1'b0, 1'b0);
        runSweep(0, 1'b0, '0, 137, 20, 1'b1, 1'b0);

        for (int k = 0; k < 3; k++) begin
            for (int v = 0; v < 256; v++) rmap[v] = ($urandom_range(0, 15) == 0);
            runSweep(0, 1'b0, rmap, int'($urandom_range(1, 300)), int'($urandom_range(1, 40)),
                     bit'($urandom_range(0, 1)), 1'b0);
        end

        runSweep(1, 1'b1, '0, 0, 0, 1'b0, 1'b0);
        for (int v = 0; v < 256; v++) rmap[v] = ($urandom_range(0, 31) == 0);
        runSweep(1, 1'b0, rmap, 0, 0, 1'b0, 1'b0);
        runSweep(1, 1'b0, '0, 0, 0, 1'b0, 1'b0);

        repeat (4) @(negedge clk);
        chk("pendingExpected", 32'(expQ0.size() + expQ1.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
